ripple_carry_adder: RTL and testbench
=====================================

// Module: ripple_carry_adder
// PURPOSE
//  - WIDTH-bit ripple-carry adder built from a chain of full-adder cells, plus a
//    registered copy of the sum (three-bit register stage).
//  - Datapath core of the accumulator.
//  - Feedback loop: the registered sum (sum_q) returns to the b operand, and the
//    carry is registered externally and returns to cin.
//  - The adder path is purely combinational. Only sum_q (and ovf_q) are clocked.
// PARAMETERS
//  - WIDTH  default 3  operand, sum and register width in bits (WIDTH >= 1)
// PORTS
//  - clk    in   1      clock, rising edge
//  - reset  in   1      asynchronous, active-high reset (clears the register stage)
//  - a      in   WIDTH  operand A (new content)
//  - b      in   WIDTH  operand B (normally fed from sum_q)
//  - cin    in   1      carry into bit 0
//  - sum    out  WIDTH  combinational sum, (a+b+cin) mod 2^WIDTH
//  - cout   out  1      combinational carry out of bit WIDTH-1
//  - sum_q  out  WIDTH  registered sum
// BEHAVIOUR
//  - Cell i:
//      s[i]   = a[i] ^ b[i] ^ c[i]
//      c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i])
//      c[0] = cin; cout = c[WIDTH].
//  - {cout,sum} == a + b + cin, exactly, for all 2^(2*WIDTH+1) input combinations.
//  - sum/cout have zero-cycle latency and no internal state; X-free for known inputs.
//  - sum_q: reset asserted -> WIDTH'b0 immediately, independent of clk.
//  - sum_q: otherwise on every posedge clk, sum_q <= sum. No enable; 1-cycle latency.
//  - Reset dominates: posedge clk while reset=1 keeps sum_q = 0.
//  - On reset release, the first rising edge loads the current sum.
//  - Wrap-around: 3'b111 + 3'b001 + 0 -> sum=3'b000, cout=1; no saturation.
//  - Max case: 3'b111 + 3'b111 + 1 -> sum=3'b111, cout=1.
//  - Outputs after reset: sum_q=0; sum/cout follow the inputs.
// CONFIGURATION
//  - Macro RCA_OVERFLOW_EN.
//  - Defined: adds output ovf (1 bit) = c[WIDTH] ^ c[WIDTH-1], the two's-complement
//    signed overflow.
//  - Defined: adds output ovf_q (1 bit), registered exactly like sum_q (async reset to 0).
//  - Undefined: ovf and ovf_q ports do not exist. All other behaviour is identical.
// TESTING
//  - Exhaustive (WIDTH=3): all a, b, cin -> {cout,sum}==a+b+cin; 128 vectors, 0 mismatches.
//  - Register: a=3,b=2,cin=0 -> sum=5 at once; sum_q=5 after the next posedge.
//  - Async reset: sum_q=5, assert reset mid-cycle -> sum_q=0 before the next clk edge;
//    stays 0 across edges while reset=1.
//  - Wrap: a=7,b=1,cin=0 -> sum=0, cout=1; a=7,b=7,cin=1 -> sum=7, cout=1.
//  - Accumulate loop: b<=sum_q, cin<=registered cout, a=3 each cycle from reset ->
//    sum_q = 3, 6, 1(c=1), 5, 0(c=1), 4, ...
//  - RCA_OVERFLOW_EN: a=3,b=1,cin=0 -> ovf=1; a=4(-4),b=7(-1),cin=0 -> ovf=1;
//    a=1,b=1 -> ovf=0.

Source files
------------

// File: rtl/ripple_carry_adder_if.sv
// Operand/result bundle for ripple_carry_adder. ovf/ovf_q exist only when
// RCA_OVERFLOW_EN is defined.
interface ripple_carry_adder_if #(
  parameter int unsigned WIDTH = 3
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [WIDTH-1:0] sum_q;
`ifdef RCA_OVERFLOW_EN
  logic             ovf;
  logic             ovf_q;
`endif

  modport master (
    output a, b, cin,
    input  sum, cout, sum_q
`ifdef RCA_OVERFLOW_EN
    , input ovf, ovf_q
`endif
  );

  modport slave (
    input  a, b, cin,
    output sum, cout, sum_q
`ifdef RCA_OVERFLOW_EN
    , output ovf, ovf_q
`endif
  );
endinterface

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder with a registered copy of the sum.
// Optional signed-overflow outputs (ovf, ovf_q) under macro RCA_OVERFLOW_EN.
module ripple_carry_adder #(
  parameter int unsigned WIDTH = 3
) (
  input  logic                clk,
  input  logic                reset,
  ripple_carry_adder_if.slave bus
);

  logic [WIDTH-1:0] sum_c;
  logic             carry;
  logic             carry_msb;
  logic [WIDTH-1:0] sum_q;

  // Carry ripples through a blocking variable so the chain stays one
  // combinational block; carry_msb keeps the carry into the top cell.
  always_comb begin
    sum_c     = '0;
    carry     = bus.cin;
    carry_msb = bus.cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      carry_msb = carry;
      sum_c[i]  = bus.a[i] ^ bus.b[i] ^ carry;
      carry     = (bus.a[i] & bus.b[i]) | (carry & (bus.a[i] ^ bus.b[i]));
    end
  end

  assign bus.sum  = sum_c;
  assign bus.cout = carry;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sum_q <= '0;
    else       sum_q <= sum_c;
  end

  assign bus.sum_q = sum_q;

`ifdef RCA_OVERFLOW_EN
  logic ovf_c;
  logic ovf_q;

  assign ovf_c = carry ^ carry_msb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_c;
  end

  assign bus.ovf   = ovf_c;
  assign bus.ovf_q = ovf_q;
`endif

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder (WIDTH=3) against an arithmetic
// reference model.
module tb_ripple_carry_adder;
  localparam int unsigned W = 3;

  logic clk;
  logic reset;
  int unsigned n_vec;
  int unsigned n_err;

  ripple_carry_adder_if #(.WIDTH(W)) bus ();

  ripple_carry_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int unsigned av, input int unsigned bv, input int unsigned cv);
    logic [31:0] t;
    t = av; bus.a = t[W-1:0];
    t = bv; bus.b = t[W-1:0];
    t = cv; bus.cin = t[0];
  endtask

  function automatic int unsigned ref_total(input int unsigned av, input int unsigned bv,
                                            input int unsigned cv);
    return av + bv + cv;
  endfunction

`ifdef RCA_OVERFLOW_EN
  function automatic int unsigned ref_ovf(input int unsigned av, input int unsigned bv,
                                          input int unsigned cv);
    int sa, sb, s;
    sa = (av >= 4) ? int'(av) - 8 : int'(av);
    sb = (bv >= 4) ? int'(bv) - 8 : int'(bv);
    s  = sa + sb + int'(cv);
    return (s > 3 || s < -4) ? 1 : 0;
  endfunction
`endif

  task automatic check_comb(input string tag, input int unsigned av, input int unsigned bv,
                            input int unsigned cv);
    int unsigned tot;
    tot = ref_total(av, bv, cv);
    check_val(tag, {28'b0, bus.cout, bus.sum}, tot);
`ifdef RCA_OVERFLOW_EN
    check_val({tag, "_ovf"}, {31'b0, bus.ovf}, ref_ovf(av, bv, cv));
`endif
  endtask

  initial begin
    int unsigned av, bv, cv, exp_q, acc, creg;
`ifdef RCA_OVERFLOW_EN
    int unsigned exp_ovf;
`endif
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    drive(3, 2, 0);
    #2;
    check_val("reset_sum_q", {29'b0, bus.sum_q}, 0);
    tick();
    check_val("reset_hold_sum_q", {29'b0, bus.sum_q}, 0);
    check_val("reset_comb_sum", {29'b0, bus.sum}, 5);

    // Exhaustive combinational sweep
    for (int i = 0; i < 128; i++) begin
      av = i & 7; bv = (i >> 3) & 7; cv = (i >> 6) & 1;
      drive(av, bv, cv);
      #1;
      check_comb("exh", av, bv, cv);
    end

    // Wrap and max cases
    drive(7, 1, 0); #1;
    check_val("wrap_sum", {29'b0, bus.sum}, 0);
    check_val("wrap_cout", {31'b0, bus.cout}, 1);
    drive(7, 7, 1); #1;
    check_val("max_sum", {29'b0, bus.sum}, 7);
    check_val("max_cout", {31'b0, bus.cout}, 1);

    // First edge after release loads current sum
    @(negedge clk);
    reset = 1'b0;
    drive(3, 2, 0); #1;
    check_val("reg_comb", {29'b0, bus.sum}, 5);
    check_val("reg_before_edge", {29'b0, bus.sum_q}, 0);
    tick();
    check_val("reg_sum_q", {29'b0, bus.sum_q}, 5);

    // Async reset mid-cycle
    #2;
    reset = 1'b1;
    #1;
    check_val("async_reset", {29'b0, bus.sum_q}, 0);
    tick();
    check_val("reset_edge1", {29'b0, bus.sum_q}, 0);
    tick();
    check_val("reset_edge2", {29'b0, bus.sum_q}, 0);
`ifdef RCA_OVERFLOW_EN
    check_val("reset_ovf_q", {31'b0, bus.ovf_q}, 0);
    drive(3, 1, 0); #1;
    check_val("ovf_3p1", {31'b0, bus.ovf}, 1);
    drive(4, 7, 0); #1;
    check_val("ovf_m4m1", {31'b0, bus.ovf}, 1);
    drive(1, 1, 0); #1;
    check_val("ovf_1p1", {31'b0, bus.ovf}, 0);
`endif

    // Accumulate loop: b <= sum_q, cin <= registered cout, a = 3
    @(negedge clk);
    drive(3, 0, 0);
    reset = 1'b0;
    acc = 0;
    creg = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      acc = acc + 3 + creg;
      creg = acc >> 3;
      acc = acc & 7;
      check_val("accum_sum_q", {29'b0, bus.sum_q}, acc);
      drive(3, bus.sum_q, bus.cout);
    end

    // Randomized vectors with registered-output tracking
    for (int k = 0; k < 200; k++) begin
      av = $urandom_range(7); bv = $urandom_range(7); cv = $urandom_range(1);
      drive(av, bv, cv);
      #1;
      check_comb("rand", av, bv, cv);
      exp_q = ref_total(av, bv, cv) & 7;
`ifdef RCA_OVERFLOW_EN
      exp_ovf = ref_ovf(av, bv, cv);
`endif
      tick();
      check_val("rand_sum_q", {29'b0, bus.sum_q}, exp_q);
`ifdef RCA_OVERFLOW_EN
      check_val("rand_ovf_q", {31'b0, bus.ovf_q}, exp_ovf);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
